// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_write_arbiter
// Brief    : Round-robin arbiter that lets four requesters write a shared
//            W-bit D-register. Grant is registered (IDLE -> GRANT -> commit),
//            with a one-cycle done pulse and a wrapping 8-bit write counter.
//            Optional macro DFF_ARB_LOCK_EN lets a locked requester keep the
//            grant and write every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dff_write_arbiter #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    input  logic [N-1:0]   lock,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic [N-1:0]   done,
    output logic [7:0]     wr_cnt
);

    localparam int c_IW = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    w_gnt_nxt;
    logic [W-1:0]    r_q;
    logic [W-1:0]    w_q_nxt;
    logic [N-1:0]    r_done;
    logic [N-1:0]    w_done_nxt;
    logic [7:0]      r_wr_cnt;
    logic [7:0]      w_wr_cnt_nxt;
    logic [c_IW-1:0] r_ptr;
    logic [c_IW-1:0] w_ptr_nxt;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] w_idx_nxt;

    logic            w_found;
    logic [c_IW-1:0] w_pick;
    logic [c_IW-1:0] w_cand;
    logic            w_hold;

    // Round-robin pick: first asserted request searching upward from ptr
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_cand = r_ptr + c_IW'(k);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Whether the current grant is kept after a commit
    always_comb begin
`ifdef DFF_ARB_LOCK_EN
        w_hold = lock[r_idx];
`else
        // lock is accepted on the port but has no effect in this build
        w_hold = lock[r_idx] & 1'b0;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_q_nxt      = r_q;
        w_done_nxt   = '0;
        w_wr_cnt_nxt = r_wr_cnt;
        w_ptr_nxt    = r_ptr;
        w_idx_nxt    = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_idx_nxt   = w_pick;
                    w_gnt_nxt   = N'(1) << w_pick;
                end
            end
            ST_GRANT: begin
                if (req[r_idx]) begin
                    // Commit: only the granted lane is sampled
                    w_q_nxt      = wdata[int'(r_idx) * W +: W];
                    w_done_nxt   = N'(1) << r_idx;
                    w_wr_cnt_nxt = r_wr_cnt + 8'd1;
                    if (!w_hold) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = r_idx + 1'b1;
                    end
                end else begin
                    // Withdrawal: drop the grant, nothing else changes
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_q      <= '0;
            r_done   <= '0;
            r_wr_cnt <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_q      <= w_q_nxt;
            r_done   <= w_done_nxt;
            r_wr_cnt <= w_wr_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign q      = r_q;
    assign done   = r_done;
    assign wr_cnt = r_wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_write_arbiter
// Brief    : Directed self-checking bench for dff_write_arbiter: reset,
//            single write, round robin, withdrawal, non-preemption, counter
//            wrap and lock behaviour (enabled or ignored per build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  lock;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic [3:0]  done;
    logic [7:0]  wr_cnt;

    int n_checks;
    int n_errors;
    int pulses;

    dff_write_arbiter #(.W(8), .N(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .wdata  (wdata),
        .lock   (lock),
        .gnt    (gnt),
        .q      (q),
        .done   (done),
        .wr_cnt (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] e_oh;
        n_checks = 0;
        n_errors = 0;
        pulses   = 0;
        rst_n    = 1'b0;
        req      = 4'b1111;
        lock     = 4'b0000;
        wdata    = 32'h0;

        // Reset held with all requests high
        tick();
        tick();
        check("rst_gnt",  32'(gnt),    32'h0);
        check("rst_q",    32'(q),      32'h0);
        check("rst_cnt",  32'(wr_cnt), 32'h0);
        check("rst_done", 32'(done),   32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("rel_wd_gnt", 32'(gnt),    32'h0);
        check("rel_wd_cnt", 32'(wr_cnt), 32'h0);

        // Single write from requester 2
        wdata[16 +: 8] = 8'hA5;
        req = 4'b0100;
        tick();
        check("sw_gnt", 32'(gnt), 32'h4);
        tick();
        check("sw_q",      32'(q),      32'hA5);
        check("sw_done",   32'(done),   32'h4);
        check("sw_cnt",    32'(wr_cnt), 32'h1);
        check("sw_gnt0",   32'(gnt),    32'h0);
        req = 4'b0000;
        tick();
        check("sw_done_off", 32'(done), 32'h0);
        check("sw_q_hold",   32'(q),    32'hA5);

        // Reset asserted mid-grant discards the pending write
        req = 4'b0100;
        tick();
        check("mg_gnt", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        #1;
        check("mg_gnt_rst", 32'(gnt),    32'h0);
        check("mg_q_rst",   32'(q),      32'h0);
        check("mg_cnt_rst", 32'(wr_cnt), 32'h0);
        tick();
        rst_n = 1'b1;

        // Round robin with all four requesting
        wdata = 32'h13121110;
        req   = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            e_oh = 4'b0001 << (i % 4);
            tick();
            check("rr_gnt", 32'(gnt), 32'(e_oh));
            tick();
            check("rr_q",    32'(q),    32'h10 + 32'(i % 4));
            check("rr_done", 32'(done), 32'(e_oh));
        end
        check("rr_cnt", 32'(wr_cnt), 32'd8);

        // Withdrawal keeps everything, pointer included
        req = 4'b0010;
        tick();
        check("wd_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check("wd_gnt0", 32'(gnt),    32'h0);
        check("wd_q",    32'(q),      32'h13);
        check("wd_done", 32'(done),   32'h0);
        check("wd_cnt",  32'(wr_cnt), 32'd8);
        req = 4'b1010;
        tick();
        check("wd_regnt", 32'(gnt), 32'h2);
        tick();
        check("wd_q2",   32'(q),      32'h11);
        check("wd_cnt2", 32'(wr_cnt), 32'd9);

        // Late request does not preempt the current grant
        req = 4'b1000;
        tick();
        check("np_gnt", 32'(gnt), 32'h8);
        req = 4'b1001;
        tick();
        check("np_q",    32'(q),      32'h13);
        check("np_done", 32'(done),   32'h8);
        check("np_cnt",  32'(wr_cnt), 32'd10);
        req = 4'b0000;
        tick();

        // Counter wrap over 256 writes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (done != 4'b0000) pulses++;
            if (i == 509) check("wrap_255", 32'(wr_cnt), 32'd255);
        end
        req = 4'b0000;
        check("wrap_cnt",    32'(wr_cnt), 32'd0);
        check("wrap_pulses", 32'(pulses), 32'd256);
        check("wrap_q",      32'(q),      32'h10);

        // Lock behaviour
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req  = 4'b1001;
        lock = 4'b0001;
        tick();
        check("lk_gnt", 32'(gnt), 32'h1);
`ifdef DFF_ARB_LOCK_EN
        for (int j = 0; j < 3; j++) begin
            wdata[0 +: 8] = 8'h20 + 8'(j);
            tick();
            check("lk_q",    32'(q),    32'h20 + 32'(j));
            check("lk_done", 32'(done), 32'h1);
            check("lk_gnt_hold", 32'(gnt), 32'h1);
        end
        check("lk_cnt", 32'(wr_cnt), 32'd3);
        lock = 4'b0000;
        wdata[0 +: 8] = 8'h30;
        tick();
        check("lk_rel_q",   32'(q),      32'h30);
        check("lk_rel_gnt", 32'(gnt),    32'h0);
        check("lk_rel_cnt", 32'(wr_cnt), 32'd4);
        tick();
        check("lk_next_gnt", 32'(gnt), 32'h8);
`else
        wdata[0 +: 8] = 8'h20;
        tick();
        check("nl_q",    32'(q),    32'h20);
        check("nl_gnt0", 32'(gnt),  32'h0);
        check("nl_done", 32'(done), 32'h1);
        tick();
        check("nl_gnt3", 32'(gnt), 32'h8);
        tick();
        check("nl_q3",   32'(q),      32'h13);
        check("nl_done3", 32'(done),  32'h8);
        check("nl_cnt",  32'(wr_cnt), 32'd2);
`endif
        req  = 4'b0000;
        lock = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter W, default 8, shall set the width of the shared D-register and of each requester data lane.
REQ-002 Parameter N, default 4, shall set the number of requesters; it is fixed at 4 in this release.
REQ-003 clk  input  1  shall be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 req  input  4  shall carry one write-request bit per requester; bit i belongs to requester i.
REQ-006 wdata  input  4*W  shall carry the requester data lanes; requester i owns bits [i*W+W-1 : i*W].
REQ-007 lock  input  4  shall carry one bus-hold bit per requester (see REQ-024).
REQ-008 gnt  output  4  shall be the one-hot grant, or all-zero when no requester holds the register.
REQ-009 q  output  W  shall be the shared D-register contents.
REQ-010 done  output  4  shall pulse one-hot for exactly one cycle after each committed write.
REQ-011 wr_cnt  output  8  shall count committed writes.

Function
REQ-012 The FSM shall have two states: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-013 In IDLE with req≠0, the next edge shall select the requester and enter GRANT.
  - Selection: first set bit of req searching upward from ptr, modulo 4.
REQ-014 In IDLE with req=0, the state shall remain IDLE and q shall hold its value.
REQ-015 gnt shall be a registered output, asserted in the cycle after the edge that samples req, with 1-cycle request-to-grant latency.
REQ-016 In GRANT for requester g with req[g]=1, the next edge shall:
  - load q from lane g;
  - assert done[g] for the following cycle;
  - increment wr_cnt;
  - set ptr to (g+1) mod 4;
  - return to IDLE unless REQ-024 applies.
REQ-017 In GRANT with req[g]=0 (requester withdraws), the next edge shall:
  - return to IDLE;
  - leave q, wr_cnt and ptr unchanged;
  - keep done at zero.
REQ-018 Requests from other requesters that arrive during GRANT shall be queued only by their held req level; they shall not preempt the current grant.
REQ-019 wr_cnt shall wrap from 255 to 0 without saturating.
REQ-020 Round-robin fairness: with all four req held high, the grant order shall be 0,1,2,3,0,...; each requester is served within at most 4 grants.
REQ-021 Write throughput without lock shall be one write per 2 cycles: IDLE→GRANT→IDLE.
REQ-022 The wdata lanes shall be sampled only at the committing edge; lanes of non-granted requesters shall be ignored.

Reset
REQ-023 While rst_n=0, the block shall asynchronously force state=IDLE, gnt=0, done=0, q=0, wr_cnt=0 and ptr=0.
  - Reset asserted mid-GRANT shall discard the pending write.
  - Operation shall resume at the first rising clk edge after rst_n rises.

Configuration
REQ-024 With macro DFF_ARB_LOCK_EN defined, a commit with lock[g]=1 and req[g]=1 shall stay in GRANT for g, allowing one write per cycle.
  - done[g] shall pulse on each commit.
  - ptr shall update only when the grant is released.
REQ-025 Without DFF_ARB_LOCK_EN, the lock port shall remain present but be ignored, and every commit shall return to IDLE.

Verification
REQ-026 Reset: hold rst_n=0 and drive req=4'b1111 → gnt=0, q=0, wr_cnt=0, done=0; release rst_n → gnt=4'b0001 one cycle later.
REQ-027 Single write: req=4'b0100 with lane 2 = 8'hA5 → next cycle gnt=4'b0100; next cycle q=8'hA5, done=4'b0100, wr_cnt=1, gnt=0.
REQ-028 Round robin: req=4'b1111 held for 8 writes with lane i = 8'h10+i → q sequence 10,11,12,13,10,11,12,13; wr_cnt=8.
REQ-029 Withdrawal: req=4'b0010 granted, then req dropped to 0 during GRANT → q unchanged, done=0, wr_cnt unchanged, next request from requester 1 still granted first.
REQ-030 Wrap: perform 256 single writes → wr_cnt returns to 0 and done pulses 256 times.
REQ-031 Lock build: define DFF_ARB_LOCK_EN, hold req=4'b1001 and lock=4'b0001 for 3 cycles of grant → three consecutive writes from lane 0; drop lock → next grant goes to requester 3.
